drap_fetch_pc: RTL and testbench
================================

// Module: drap_fetch_pc
// PURPOSE
// - PC register and instruction-fetch sequencer for the DRAP MIPS datapath; downstream consumer of the shift-left-2 branch offset.
// - Holds the PC and issues one word request at a time to instruction memory over a req/ack handshake.
// - Presents the fetched instruction and PC+4 to decode.
// - Computes the next PC as sequential, branch (PC+4 + shifted offset), jump ({PC+4[31:28], target, 2'b00}) or flush.
// PARAMETERS
// - RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] ignored (treated as 0)
// PORTS
// - clk            in   1   system clock, rising edge
// - rst            in   1   asynchronous, active-high reset
// - stall          in   1   decode cannot accept; holds the presented instruction
// - branch_taken   in   1   taken branch for the instruction on instr_out
// - branch_off     in   32  sign-extended word offset, already shifted left 2
// - jump           in   1   J-type jump for the instruction on instr_out
// - jump_target    in   26  instr_index field of the jump
// - flush          in   1   discard current/outstanding fetch and redirect
// - flush_pc       in   32  redirect address when flush=1; bits [1:0] forced 0
// - imem_req       out  1   fetch request to instruction memory
// - imem_addr      out  32  fetch word address; low 2 bits always 0
// - imem_ack       in   1   memory returns imem_rdata this cycle
// - imem_rdata     in   32  instruction word
// - instr_out      out  32  instruction to decode
// - pc4_out        out  32  address of instr_out + 4
// - valid_out      out  1   instr_out/pc4_out valid
// BEHAVIOUR
// - Reset (async, immediate): pc=RESET_PC, state=IDLE, imem_req=0, valid_out=0, instr_out=0, pc4_out=0, drop=0.
//   Reset mid-request abandons it; an ack arriving during reset is ignored.
// - FSM states: IDLE, REQ, VALID.
// - IDLE: first edge after rst deasserts -> REQ, with imem_req=1 and imem_addr=pc.
// - REQ:
//   - imem_req=1; imem_addr is held stable until imem_ack.
//   - On ack with drop=0: instr_out<=imem_rdata, pc4_out<=pc+4, valid_out<=1 -> VALID.
//   - On ack with drop=1: discard data, clear drop, stay in REQ with the new pc.
// - VALID:
//   - valid_out=1; imem_req=0; outputs are held while stall=1.
//   - When stall=0, the instruction is consumed that cycle and on the edge: valid_out<=0, pc<=next_pc -> REQ.
//   - Minimum 2 cycles per instruction (request issue + ack).
// - next_pc priority: flush > jump > branch_taken > sequential.
//   - jump: {pc4_out[31:28], jump_target, 2'b00}.
//   - branch: pc4_out + branch_off, modulo 2^32 (wraps, no overflow flag).
//   - sequential: pc4_out (0xFFFF_FFFC + 4 wraps to 0).
// - jump/branch_taken are sampled only when VALID and stall=0; they are ignored in IDLE/REQ.
// - flush (any state, synchronous):
//   - pc<=flush_pc & ~3, valid_out<=0.
//   - In VALID -> REQ.
//   - In REQ without same-cycle ack: set drop=1 and keep imem_addr until ack (req/addr stable rule), then re-request.
//   - In REQ with same-cycle ack: data discarded, drop stays 0, re-request next cycle.
//   - flush overrides stall.
// - imem_ack outside REQ is ignored.
// TESTING
// - rst pulse, RESET_PC=0 -> req=1 addr=0x0 next cycle; ack rdata=0x2002_0005 -> valid=1 instr=0x2002_0005 pc4=0x4.
// - 3 sequential fetches, ack 1 cycle after req, no stall -> addrs 0x0,0x4,0x8; each valid for exactly 1 cycle.
// - pc4=0x10, branch_taken=1, branch_off=0xFFFF_FFF0 -> next addr 0x0; branch_off=0x20 -> 0x30.
// - pc4=0x1000_0004, jump=1, jump_target=0x000_0040, branch_taken=1 -> addr 0x1000_0100 (jump wins).
// - stall=1 for 5 cycles in VALID -> instr/pc4/valid unchanged, req=0; stall drop -> next req.
// - flush(flush_pc=0x80) in REQ, ack 3 cycles later with 0xDEAD_BEEF -> no valid, then req addr 0x80; rst in REQ -> req=0 at once.

Source files
------------

// File: rtl/drap_fetch_pc.sv
// PC register and instruction-fetch sequencer: one outstanding word request to
// instruction memory, next-PC selection from sequential/branch/jump/flush.
module drap_fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;

  logic [31:0] flush_addr;
  logic [31:0] next_pc;

  assign flush_addr = flush_pc & WORD_MASK;

  always_comb begin
    if (jump)              next_pc = {pc4_q[31:28], jump_target, 2'b00};
    else if (branch_taken) next_pc = pc4_q + branch_off;
    else                   next_pc = pc4_q;
  end

  // addr_q is separate from pc_q so the memory address stays stable while a
  // flushed request is still waiting for its ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (flush) pc_d = flush_addr;
        addr_d  = pc_d;
        state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (flush) begin
            pc_d   = flush_addr;
            addr_d = flush_addr;
            drop_d = 1'b0;
          end else if (drop_q) begin
            drop_d = 1'b0;
            addr_d = pc_q;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = addr_q + 32'd4;
            valid_d = 1'b1;
            state_d = VALID;
          end
        end else if (flush) begin
          pc_d   = flush_addr;
          drop_d = 1'b1;
        end
      end
      VALID: begin
        if (flush)       pc_d = flush_addr;
        else if (!stall) pc_d = next_pc;
        if (flush || !stall) begin
          valid_d = 1'b0;
          addr_d  = pc_d;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & WORD_MASK;
      addr_q  <= RESET_PC & WORD_MASK;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = addr_q;
  assign instr_out = instr_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_drap_fetch_pc.sv
// Directed and randomized bench for drap_fetch_pc; the bench plays memory and
// decode and predicts each fetch address from the next-PC rules.
module tb_drap_fetch_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, jump, flush, imem_ack;
  logic [31:0] branch_off, flush_pc, imem_rdata;
  logic [25:0] jump_target;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instr_out, pc4_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  drap_fetch_pc #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_off(branch_off), .jump(jump), .jump_target(jump_target),
    .flush(flush), .flush_pc(flush_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc4_out(pc4_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request at addr, ack it after lat cycles, check the delivered instruction.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int unsigned lat);
    int unsigned n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, addr);
    for (int unsigned i = 0; i < lat; i++) begin
      tick();
      chk("req_hold", {31'd0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("valid", {31'd0, valid_out}, 32'd1);
    chk("instr", instr_out, data);
    chk("pc4", pc4_out, addr + 32'd4);
    chk("req_in_valid", {31'd0, imem_req}, 32'd0);
  endtask

  // Hold the instruction under stall for n cycles.
  task automatic hold(input int unsigned n, input logic [31:0] addr, input logic [31:0] data);
    stall = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      chk("stall_valid", {31'd0, valid_out}, 32'd1);
      chk("stall_instr", instr_out, data);
      chk("stall_pc4", pc4_out, addr + 32'd4);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
  endtask

  // Consume the instruction at cur with the given redirect inputs; returns the predicted next PC.
  task automatic consume(input logic [31:0] cur, input logic st, input logic fl, input logic [31:0] fpc,
                         input logic j, input logic [25:0] tgt, input logic br,
                         input logic [31:0] off, output logic [31:0] nxt);
    logic [31:0] pc4;
    pc4 = cur + 32'd4;
    if (fl)      nxt = fpc - (fpc % 32'd4);
    else if (j)  nxt = (pc4 & 32'hF000_0000) + ({6'd0, tgt} * 32'd4);
    else if (br) nxt = pc4 + off;
    else         nxt = pc4;
    stall = st; flush = fl; flush_pc = fpc;
    jump = j; jump_target = tgt; branch_taken = br; branch_off = off;
    tick();
    stall = 1'b0; flush = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    flush_pc = $urandom; jump_target = 26'($urandom); branch_off = $urandom;
    chk("consumed_valid", {31'd0, valid_out}, 32'd0);
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, nxt);
  endtask

  initial begin
    logic [31:0] pc, d, off, fpc;
    logic [25:0] tgt;
    int unsigned op;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; flush = 1'b0;
    imem_ack = 1'b0; branch_off = '0; flush_pc = '0; jump_target = '0; imem_rdata = '0;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc4", pc4_out, 32'd0);
    rst = 1'b0;
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Three sequential fetches, then branches backward and forward.
    fetch(32'h0, 32'h2002_0005, 0);
    consume(32'h0, 0, 0, 0, 0, 0, 0, 0, pc);
    fetch(pc, 32'h1111_1111, 1);
    consume(pc, 0, 0, 0, 0, 0, 0, 0, pc);
    chk("seq_addr8", pc, 32'h8);
    fetch(pc, 32'h2222_2222, 1);
    consume(pc, 0, 0, 0, 0, 0, 0, 0, pc);
    fetch(pc, 32'h3333_3333, 0);
    consume(pc, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF0, pc);
    chk("branch_back", pc, 32'h0);
    fetch(pc, 32'h4444_4444, 0);
    consume(pc, 0, 0, 0, 0, 0, 1, 32'h8, pc);
    fetch(pc, 32'h5555_5555, 0);
    consume(pc, 0, 0, 0, 0, 0, 1, 32'h20, pc);
    chk("branch_fwd", pc, 32'h30);

    // Jump beats branch.
    fetch(pc, 32'h6666_6666, 0);
    consume(pc, 0, 1, 32'h1000_0000, 0, 0, 0, 0, pc);
    fetch(pc, 32'h0800_0040, 2);
    consume(pc, 0, 0, 0, 1, 26'h40, 1, 32'h100, pc);
    chk("jump_wins", pc, 32'h1000_0100);

    // Stall hold, then top-of-memory wrap.
    fetch(pc, 32'h7777_7777, 0);
    hold(5, pc, 32'h7777_7777);
    consume(pc, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, pc);
    fetch(pc, 32'h8888_8888, 0);
    chk("wrap_pc4", pc4_out, 32'h0);
    consume(pc, 0, 0, 0, 0, 0, 0, 0, pc);

    // Flush while a request is outstanding: old address held, data dropped.
    flush = 1'b1; flush_pc = 32'h0000_0083;
    tick();
    flush = 1'b0;
    chk("flush_req_hold", {31'd0, imem_req}, 32'd1);
    chk("flush_addr_hold", imem_addr, 32'h0);
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("drop_no_valid", {31'd0, valid_out}, 32'd0);
    chk("drop_rereq", {31'd0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'h80);
    fetch(32'h80, 32'h9999_9999, 0);
    consume(32'h80, 1, 1, 32'h0000_0200, 0, 0, 0, 0, pc);

    // Reset mid-request is immediate; an ack during reset is ignored.
    rst = 1'b1;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hABCD_0123;
    tick();
    imem_ack = 1'b0;
    chk("rst_ack_ignored", {31'd0, valid_out}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rerst_addr", imem_addr, 32'h0);
    pc = 32'h0;

    // Randomized traffic against the next-PC rules.
    for (int unsigned k = 0; k < 60; k++) begin
      d = $urandom;
      fetch(pc, d, $urandom_range(0, 3));
      hold($urandom_range(0, 2), pc, d);
      op  = $urandom_range(0, 9);
      tgt = 26'($urandom);
      off = $urandom & 32'hFFFF_FFFC;
      fpc = $urandom;
      case (op)
        0:       consume(pc, 1'($urandom), 1, fpc, 1'($urandom), tgt, 1'($urandom), off, pc);
        1, 2:    consume(pc, 0, 0, fpc, 1, tgt, 1'($urandom), off, pc);
        3, 4, 5: consume(pc, 0, 0, fpc, 0, tgt, 1, off, pc);
        default: consume(pc, 0, 0, fpc, 0, tgt, 0, off, pc);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
